// File: rtl/dispatch_pkg.sv
// Shared defaults and the round-robin pick helper for rr_work_dispatcher.
package dispatch_pkg;

  localparam int DEFAULT_NUM_CORES   = 4;
  localparam int DEFAULT_ITEM_W      = 4;
  localparam int DEFAULT_QUEUE_DEPTH = 4;

  // Upper bound on NUM_CORES that rr_pick can search.
  localparam int MAX_CORES = 32;

  typedef struct packed {
    logic found;
    int   idx;
  } pick_t;

  // First set bit of idle_mask at or after ptr, wrapping modulo n.
  function automatic pick_t rr_pick(input logic [MAX_CORES-1:0] idle_mask,
                                    input int ptr, input int n);
    pick_t r;
    int    c;
    r = '0;
    for (int k = 0; k < MAX_CORES; k++) begin
      if (k < n && !r.found) begin
        c = ptr + k;
        if (c >= n) c = c - n;
        if (idle_mask[c[4:0]]) begin
          r.found = 1'b1;
          r.idx   = c;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/dispatch_fifo.sv
// Synchronous FIFO holding pending work items; exposes the head and occupancy.
module dispatch_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  assign head  = mem[rd_ptr];
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  // Storage carries no reset; only pointers and count define contents.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rr_work_dispatcher.sv
// Round-robin work dispatcher: queues items and issues each to the next idle core.
// Optional DISPATCH_STATS_EN adds dispatch_count and stall_count outputs.
module rr_work_dispatcher
  import dispatch_pkg::*;
#(
  parameter int NUM_CORES   = DEFAULT_NUM_CORES,
  parameter int ITEM_W      = DEFAULT_ITEM_W,
  parameter int QUEUE_DEPTH = DEFAULT_QUEUE_DEPTH,
  localparam int CID_W = $clog2(NUM_CORES),
  localparam int QC_W  = $clog2(QUEUE_DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 dispatch_enable,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [ITEM_W-1:0]    in_item,
  input  logic [NUM_CORES-1:0] core_done,
  output logic                 dispatch_valid,
  output logic [CID_W-1:0]     dispatch_core_id,
  output logic [NUM_CORES-1:0] dispatch_grant,
  output logic [ITEM_W-1:0]    dispatch_item,
  output logic [NUM_CORES-1:0] busy_mask,
  output logic [QC_W-1:0]      queue_count,
  output logic                 idle
`ifdef DISPATCH_STATS_EN
  ,
  output logic [31:0]          dispatch_count,
  output logic [31:0]          stall_count
`endif
);

  // Handshake: an item transfers on any edge where in_valid && in_ready;
  // in_ready follows only the registered count, so a full queue refuses
  // a push even when the head is popped in the same cycle.
  logic              fifo_push;
  logic              fifo_full;
  logic              fifo_empty;
  logic [ITEM_W-1:0] fifo_head;

  logic [CID_W-1:0]     rr_ptr;
  logic [CID_W-1:0]     win;
  logic [CID_W-1:0]     next_ptr;
  logic [NUM_CORES-1:0] win_onehot;
  logic [MAX_CORES-1:0] idle_wide;
  pick_t                pick;
  logic                 decide;

  assign fifo_push = in_valid && !fifo_full;
  assign in_ready  = !fifo_full;
  assign idle      = (queue_count == '0) && (busy_mask == '0);

  dispatch_fifo #(
    .WIDTH (ITEM_W),
    .DEPTH (QUEUE_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (in_item),
    .pop       (decide),
    .head      (fifo_head),
    .count     (queue_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Search runs on the registered busy mask, so a core freed this cycle
  // is only eligible from the next one.
  always_comb begin
    idle_wide                  = '0;
    idle_wide[NUM_CORES-1:0]   = ~busy_mask;
    pick       = rr_pick(idle_wide, 32'(rr_ptr), NUM_CORES);
    win        = CID_W'(pick.idx);
    decide     = dispatch_enable && !fifo_empty && pick.found;
    win_onehot = NUM_CORES'(1) << win;
    next_ptr   = (win == CID_W'(NUM_CORES - 1)) ? '0 : win + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr           <= '0;
      busy_mask        <= '0;
      dispatch_valid   <= 1'b0;
      dispatch_core_id <= '0;
      dispatch_grant   <= '0;
      dispatch_item    <= '0;
    end else begin
      busy_mask        <= (busy_mask & ~core_done) | (decide ? win_onehot : '0);
      dispatch_valid   <= decide;
      dispatch_core_id <= decide ? win : '0;
      dispatch_grant   <= decide ? win_onehot : '0;
      dispatch_item    <= decide ? fifo_head : '0;
      if (decide) rr_ptr <= next_ptr;
    end
  end

`ifdef DISPATCH_STATS_EN
  logic stall;
  assign stall = dispatch_enable && !fifo_empty && (&busy_mask);

  always_ff @(posedge clk) begin
    if (reset) begin
      dispatch_count <= '0;
      stall_count    <= '0;
    end else begin
      if (decide) dispatch_count <= dispatch_count + 32'd1;
      if (stall)  stall_count    <= stall_count + 32'd1;
    end
  end
`endif

endmodule
